fetch_unit: RTL

- Instruction fetch stage directly downstream of the 12-bit program counter.
- Presents the PC value to program memory and holds the request until acknowledged.
- Latches the returned word into an instruction register and hands it to decode over a valid/ready handshake.
- Drives the counter's count and load controls to advance sequentially, and loads jump targets from execute.

---
 rtl/fetch_unit.sv | 72 +++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: holds a PC-addressed fetch request until acked and hands the word to decode via valid/ready.
// Define FETCH_PC_TRACE_EN to add ir_pc, the address of the instruction held in ir_out.
module fetch_unit #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_count_en,
    output logic               pc_nload,
    output logic [ADDR_W-1:0]  pc_load_value,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir_out,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               jump_req,
    input  logic [ADDR_W-1:0]  jump_target,
`ifdef FETCH_PC_TRACE_EN
    output logic [ADDR_W-1:0]  ir_pc,
`endif
    input  logic               halt
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
    state_t state, state_nx;
    logic capture;
    assign mem_addr      = pc_in;
    assign pc_load_value = jump_target;
    // A jump overrides everything: the ack is dropped and the counter loads instead of counting.
    always_comb begin
        state_nx    = state;
        capture     = 1'b0;
        mem_req     = state == FETCH;
        pc_count_en = 1'b0;
        pc_nload    = 1'b1;
        if (jump_req) begin
            pc_nload = 1'b0;
            state_nx = halt ? IDLE : FETCH;
        end else begin
            case (state)
                IDLE:    state_nx = halt ? IDLE : FETCH;
                FETCH: if (mem_ack) begin
                    capture     = 1'b1;
                    pc_count_en = 1'b1;
                    state_nx    = HOLD;
                end
                HOLD:    state_nx = ir_ready ? (halt ? IDLE : FETCH) : HOLD;
                default: state_nx = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            ir_out   <= '0;
            ir_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            if (capture) ir_out <= mem_rdata;
            ir_valid <= jump_req ? 1'b0 : capture ? 1'b1 : (state == HOLD && ir_ready) ? 1'b0 : ir_valid;
        end
    end
`ifdef FETCH_PC_TRACE_EN
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) ir_pc <= '0;
        else if (capture) ir_pc <= pc_in;
    end
`endif
endmodule
